// File: rtl/audio_adc_rx.sv
// rtl/audio_adc_rx.sv - codec ADC serial receiver producing left/right sample pairs
module audio_adc_rx #(
   parameter int DATA_WIDTH = 16,
   parameter bit I2S_MODE   = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  AUD_BCLK,
   input  logic                  AUD_ADCLRCK,
   input  logic                  AUD_ADCDAT,
   output logic [DATA_WIDTH-1:0] LEFT,
   output logic [DATA_WIDTH-1:0] RIGHT,
   output logic                  VALID,
   input  logic                  READY,
   output logic                  OVERRUN,
   input  logic                  CLR_OVR
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // A channel is either being shifted in, or already complete and waiting
   // for the next frame edge. In I2S mode the edge bit itself is the one-bit
   // delay slot, so shifting starts with the following BCLK.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   logic [2:0]            bclk_sync_q, bclk_sync_d;
   logic [1:0]            lrck_sync_q, lrck_sync_d;
   logic [1:0]            dat_sync_q, dat_sync_d;
   logic                  lr_prev_q, lr_prev_d;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  word_vld_q, word_vld_d;
   logic                  word_right_q, word_right_d;
   logic [DATA_WIDTH-1:0] lbuf_q, lbuf_d;
   logic                  left_ok_q, left_ok_d;
   logic [DATA_WIDTH-1:0] left_q, left_d;
   logic [DATA_WIDTH-1:0] right_q, right_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;

   logic bclk_rise, lr_smp, dat_smp, lr_edge;
   logic start_chan, pair_load, pair_drop;

   // synchronizer chains, BCLK rising-edge strobe and frame-edge detection
   always_comb begin
      bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
      lrck_sync_d = {lrck_sync_q[0], AUD_ADCLRCK};
      dat_sync_d  = {dat_sync_q[0], AUD_ADCDAT};
      bclk_rise   = bclk_sync_q[1] & ~bclk_sync_q[2];
      lr_smp      = lrck_sync_q[1];
      dat_smp     = dat_sync_q[1];
      lr_edge     = bclk_rise && (lr_smp != lr_prev_q);
      lr_prev_d   = bclk_rise ? lr_smp : lr_prev_q;
   end

   // channel FSM: shifts bits in and emits one finished word per channel
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      word_d       = word_q;
      word_vld_d   = 1'b0;
      word_right_d = word_right_q;
      start_chan   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // a pair must begin with a left channel
            if (lr_edge && !lr_smp) start_chan = 1'b1;
         end
         ST_SHIFT: begin
            if (lr_edge) begin
               // short word: left-align what arrived, missing LSBs read as zero
               if (cnt_q != '0) begin
                  word_vld_d   = 1'b1;
                  word_d       = shreg_q << (CNT_FULL - cnt_q);
                  word_right_d = lr_prev_q;
               end
               start_chan = 1'b1;
            end else if (bclk_rise) begin
               shreg_d = (shreg_q << 1) | DATA_WIDTH'(dat_smp);
               cnt_d   = cnt_q + CNT_ONE;
               if (cnt_q == CNT_FULL - CNT_ONE) begin
                  word_vld_d   = 1'b1;
                  word_d       = shreg_d;
                  word_right_d = lr_prev_q;
                  state_d      = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (lr_edge) start_chan = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (start_chan) begin
         state_d = ST_SHIFT;
         if (I2S_MODE) begin
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            shreg_d = DATA_WIDTH'(dat_smp);
            cnt_d   = CNT_ONE;
         end
      end
   end

   // word commit, pair register, handshake and sticky overrun
   always_comb begin
      lbuf_d    = lbuf_q;
      left_ok_d = left_ok_q;
      left_d    = left_q;
      right_d   = right_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      pair_load = 1'b0;
      if (word_vld_q) begin
         if (!word_right_q) begin
            lbuf_d    = word_q;
            left_ok_d = 1'b1;
         end else if (left_ok_q) begin
            pair_load = 1'b1;
            left_ok_d = 1'b0;
         end
      end
      pair_drop = pair_load && valid_q && !READY;
      if (valid_q && READY) valid_d = 1'b0;
      if (pair_load && !pair_drop) begin
         left_d  = lbuf_q;
         right_d = word_q;
         valid_d = 1'b1;
      end
      if (CLR_OVR) ovr_d = 1'b0;
      if (pair_drop) ovr_d = 1'b1;
   end

   // state register bank with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         bclk_sync_q  <= '0;
         lrck_sync_q  <= '0;
         dat_sync_q   <= '0;
         lr_prev_q    <= 1'b0;
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         word_q       <= '0;
         word_vld_q   <= 1'b0;
         word_right_q <= 1'b0;
         lbuf_q       <= '0;
         left_ok_q    <= 1'b0;
         left_q       <= '0;
         right_q      <= '0;
         valid_q      <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         bclk_sync_q  <= bclk_sync_d;
         lrck_sync_q  <= lrck_sync_d;
         dat_sync_q   <= dat_sync_d;
         lr_prev_q    <= lr_prev_d;
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         word_vld_q   <= word_vld_d;
         word_right_q <= word_right_d;
         lbuf_q       <= lbuf_d;
         left_ok_q    <= left_ok_d;
         left_q       <= left_d;
         right_q      <= right_d;
         valid_q      <= valid_d;
         ovr_q        <= ovr_d;
      end
   end

   assign LEFT    = left_q;
   assign RIGHT   = right_q;
   assign VALID   = valid_q;
   assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb/tb_audio_adc_rx.sv - randomized self-checking bench for audio_adc_rx
module tb_audio_adc_rx;

   localparam int DW = 16;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic bclk    = 1'b1;
   logic lrck    = 1'b0;
   logic dat     = 1'b0;
   logic ready   = 1'b1;
   logic clr_ovr = 1'b0;
   logic [DW-1:0] left_i, right_i, left_l, right_l;
   logic valid_i, valid_l, ovr_i, ovr_l;

   int checks = 0;
   int errors = 0;

   // pairs accepted by each instance (monitor-owned) and expected pairs (model-owned)
   logic [31:0] got_i[$], got_l[$], exp_i[$], exp_l[$];
   int rd_i = 0, rd_l = 0;
   int vcyc_i = 0, vcyc_l = 0;

   // reference model state: last driven LRCK, bits of the current channel,
   // pending left word per receiver mode (index 0 = left-justified, 1 = I2S)
   logic          line_lr = 1'b0;
   logic [63:0]   line_bits;
   logic [DW-1:0] m_left[2];
   logic          m_ok[2];

   always #5 clk = ~clk;

   audio_adc_rx #(.DATA_WIDTH(DW), .I2S_MODE(1'b1)) dut_i2s (
      .CLK(clk), .RST(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
      .LEFT(left_i), .RIGHT(right_i), .VALID(valid_i), .READY(ready),
      .OVERRUN(ovr_i), .CLR_OVR(clr_ovr)
   );

   audio_adc_rx #(.DATA_WIDTH(DW), .I2S_MODE(1'b0)) dut_lj (
      .CLK(clk), .RST(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
      .LEFT(left_l), .RIGHT(right_l), .VALID(valid_l), .READY(ready),
      .OVERRUN(ovr_l), .CLR_OVR(clr_ovr)
   );

   // record every accepted pair and every cycle VALID is high
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_i) vcyc_i++;
         if (valid_l) vcyc_l++;
         if (valid_i && ready) got_i.push_back({left_i, right_i});
         if (valid_l && ready) got_l.push_back({left_l, right_l});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // word a receiver should take from the channel: DW bits from 'start', zero past the end
   function automatic logic [DW-1:0] capture(input int start, input int n);
      logic [DW-1:0] w;
      w = '0;
      for (int i = 0; i < DW; i++)
         if (start + i < n) w[DW-1-i] = line_bits[start+i];
      return w;
   endfunction

   // drive one channel of n BCLK periods (BCLK = CLK/16) and update the model
   task automatic send_chan(input logic ch, input int n, input logic [31:0] word,
                            input int wbits, input bit i2s_fr);
      int            idx;
      logic          b;
      logic          fresh;
      logic [DW-1:0] w;
      fresh = (ch != line_lr);
      for (int p = 0; p < n; p++) begin
         idx = i2s_fr ? p - 1 : p;
         b = (idx >= 0 && idx < wbits) ? word[wbits-1-idx] : 1'b0;
         line_bits[p] = b;
         bclk = 1'b0;
         lrck = ch;
         dat  = b;
         tick(8);
         bclk = 1'b1;
         tick(8);
      end
      line_lr = ch;
      if (fresh) begin
         for (int m = 0; m < 2; m++) begin
            w = capture(m, n);
            if (!ch) begin
               m_left[m] = w;
               m_ok[m]   = 1'b1;
            end else if (m_ok[m]) begin
               if (m == 1) exp_i.push_back({m_left[m], w});
               else        exp_l.push_back({m_left[m], w});
               m_ok[m] = 1'b0;
            end
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      tick(n);
      rst_n = 1'b1;
      m_ok[0] = 1'b0;
      m_ok[1] = 1'b0;
   endtask

   task automatic skip_pairs();
      rd_i = got_i.size();
      rd_l = got_l.size();
      exp_i.delete();
      exp_l.delete();
   endtask

   task automatic compare(input string tag);
      int ng;
      ng = got_i.size() - rd_i;
      check({tag, " i2s pair count"}, ng, exp_i.size());
      for (int k = 0; k < ng && k < exp_i.size(); k++)
         check($sformatf("%s i2s pair %0d", tag, k), got_i[rd_i+k], exp_i[k]);
      ng = got_l.size() - rd_l;
      check({tag, " lj pair count"}, ng, exp_l.size());
      for (int k = 0; k < ng && k < exp_l.size(); k++)
         check($sformatf("%s lj pair %0d", tag, k), got_l[rd_l+k], exp_l[k]);
      skip_pairs();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " i2s LEFT"}, left_i, 0);
      check({tag, " i2s RIGHT"}, right_i, 0);
      check({tag, " i2s VALID"}, valid_i, 0);
      check({tag, " i2s OVERRUN"}, ovr_i, 0);
      check({tag, " lj LEFT"}, left_l, 0);
      check({tag, " lj VALID"}, valid_l, 0);
      check({tag, " lj OVERRUN"}, ovr_l, 0);
   endtask

   initial begin
      logic [31:0] a;
      int          vb_i, vb_l, nl, nr;

      m_ok[0] = 1'b0;
      m_ok[1] = 1'b0;
      tick(3);
      check_outputs_zero("reset");
      do_reset(1);

      // I2S-framed A5C3/3C5A, 32 BCLK per channel
      vb_i = vcyc_i; vb_l = vcyc_l;
      send_chan(1'b1, 4, 32'h0, 0, 1'b1);
      send_chan(1'b0, 32, 32'hA5C3, 16, 1'b1);
      send_chan(1'b1, 32, 32'h3C5A, 16, 1'b1);
      tick(40);
      check("i2s frame VALID low after accept", valid_i, 0);
      check("i2s frame VALID cycles", vcyc_i - vb_i, 1);
      check("i2s frame lj VALID cycles", vcyc_l - vb_l, 1);
      if (got_i.size() > rd_i) check("i2s frame i2s pair", got_i[rd_i], 32'hA5C3_3C5A);
      if (got_l.size() > rd_l) begin
         a = got_l[rd_l];
         check("i2s frame into lj LEFT", a[31:16], 16'h52E1);
      end
      send_chan(1'b0, 4, 32'h0, 0, 1'b1);
      tick(20);
      compare("i2s frame");

      // left-justified framing of the same words
      do_reset(4);
      send_chan(1'b1, 4, 32'h0, 0, 1'b0);
      send_chan(1'b0, 32, 32'hA5C3, 16, 1'b0);
      send_chan(1'b1, 32, 32'h3C5A, 16, 1'b0);
      tick(40);
      if (got_l.size() > rd_l) check("lj frame lj pair", got_l[rd_l], 32'hA5C3_3C5A);
      if (got_i.size() > rd_i) begin
         a = got_i[rd_i];
         check("lj frame into i2s LEFT", a[31:16], 16'h4B86);
      end
      send_chan(1'b0, 4, 32'h0, 0, 1'b0);
      tick(20);
      compare("lj frame");

      // overrun: consumer stalled across two frames
      do_reset(4);
      ready = 1'b0;
      send_chan(1'b1, 4, 32'h0, 0, 1'b1);
      send_chan(1'b0, 32, 32'h1111, 16, 1'b1);
      send_chan(1'b1, 32, 32'h2222, 16, 1'b1);
      send_chan(1'b0, 32, 32'h3333, 16, 1'b1);
      send_chan(1'b1, 32, 32'h4444, 16, 1'b1);
      tick(40);
      check("overrun VALID held", valid_i, 1);
      check("overrun LEFT held", left_i, 16'h1111);
      check("overrun RIGHT held", right_i, 16'h2222);
      check("overrun flag", ovr_i, 1);
      check("overrun lj flag", ovr_l, 1);
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      check("overrun cleared", ovr_i, 0);
      check("overrun VALID after clear", valid_i, 1);
      ready = 1'b1;
      tick(1);
      check("overrun VALID after accept", valid_i, 0);
      check("overrun LEFT kept after accept", left_i, 16'h1111);
      tick(2);
      skip_pairs();

      // short channels: 12 BCLK then 24 BCLK
      do_reset(4);
      send_chan(1'b1, 4, 32'h0, 0, 1'b1);
      send_chan(1'b0, 12, 32'hABC, 12, 1'b1);
      send_chan(1'b1, 12, $urandom & 32'hFFF, 12, 1'b1);
      send_chan(1'b0, 4, 32'h0, 0, 1'b1);
      tick(20);
      if (got_i.size() > rd_i) begin
         a = got_i[rd_i];
         check("short12 LEFT", a[31:16], 16'hABC0);
      end
      compare("short12");
      do_reset(4);
      send_chan(1'b1, 4, 32'h0, 0, 1'b1);
      send_chan(1'b0, 24, 32'h123456, 24, 1'b1);
      send_chan(1'b1, 24, $urandom & 32'hFFFFFF, 24, 1'b1);
      send_chan(1'b0, 4, 32'h0, 0, 1'b1);
      tick(20);
      if (got_i.size() > rd_i) begin
         a = got_i[rd_i];
         check("long24 LEFT", a[31:16], 16'h1234);
      end
      compare("long24");

      // stream joined mid-right channel, then reset in the middle of a left word
      do_reset(4);
      send_chan(1'b1, 10, $urandom, 16, 1'b1);
      send_chan(1'b0, 32, $urandom & 32'hFFFF, 16, 1'b1);
      send_chan(1'b1, 32, $urandom & 32'hFFFF, 16, 1'b1);
      tick(10);
      compare("midjoin");
      ready = 1'b0;
      a = $urandom & 32'hFFFF;
      send_chan(1'b0, 32, a, 16, 1'b1);
      send_chan(1'b1, 32, $urandom & 32'hFFFF, 16, 1'b1);
      tick(10);
      check("pre-reset VALID", valid_i, 1);
      check("pre-reset LEFT", left_i, a[15:0]);
      send_chan(1'b0, 8, $urandom, 16, 1'b1);
      rst_n = 1'b0;
      tick(3);
      check_outputs_zero("mid-word reset");
      do_reset(1);
      skip_pairs();
      ready = 1'b1;
      vb_i = vcyc_i;
      send_chan(1'b0, 24, $urandom, 16, 1'b1);
      send_chan(1'b1, 32, $urandom & 32'hFFFF, 16, 1'b1);
      tick(10);
      check("resync no VALID before left edge", vcyc_i - vb_i, 0);
      send_chan(1'b0, 32, $urandom & 32'hFFFF, 16, 1'b1);
      send_chan(1'b1, 32, $urandom & 32'hFFFF, 16, 1'b1);
      send_chan(1'b0, 4, 32'h0, 0, 1'b1);
      tick(20);
      compare("resync");

      // back-to-back random frames with random channel lengths, both framings
      for (int fr = 0; fr < 2; fr++) begin
         do_reset(4);
         ready = 1'b1;
         vb_i = vcyc_i; vb_l = vcyc_l;
         send_chan(1'b1, 4, 32'h0, 0, fr[0]);
         for (int k = 0; k < 8; k++) begin
            nl = $urandom_range(36, 10);
            nr = $urandom_range(36, 10);
            send_chan(1'b0, nl, $urandom & 32'hFFFFFF, 24, fr[0]);
            send_chan(1'b1, nr, $urandom & 32'hFFFFFF, 24, fr[0]);
         end
         send_chan(1'b0, 4, 32'h0, 0, fr[0]);
         tick(20);
         check($sformatf("random fr%0d i2s VALID cycles", fr), vcyc_i - vb_i, 8);
         check($sformatf("random fr%0d lj VALID cycles", fr), vcyc_l - vb_l, 8);
         check($sformatf("random fr%0d i2s OVERRUN", fr), ovr_i, 0);
         check($sformatf("random fr%0d lj OVERRUN", fr), ovr_l, 0);
         compare($sformatf("random fr%0d", fr));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
